// File: rtl/multi_channel_timer.sv
// rtl/multi_channel_timer.sv - parametrised multi-channel cycle timer
//
// Purpose:
//   NUM_CH independent cycle timers. Each one has its own terminal value,
//   one-shot/periodic mode, pause, abort/retrigger and a sticky irq flag.
//
// Ports:
//   clk          in   1             rising-edge clock
//   rst_n        in   1             synchronous active-low reset
//   start_i      in   NUM_CH        start/retrigger strobe (latches n_i, periodic_i)
//   stop_i       in   NUM_CH        abort strobe, highest priority
//   pause_i      in   NUM_CH        hold count while high (RUN/PAUSED only)
//   periodic_i   in   NUM_CH        1=auto-reload, 0=one-shot
//   n_i          in   NUM_CH*WIDTH  terminal values, ch k at [k*WIDTH +: WIDTH]
//   irq_clr_i    in   NUM_CH        clear sticky irq bit
//   curr_time_q  out  NUM_CH*WIDTH  current count per channel
//   curr_end_q   out  NUM_CH        terminal indication
//   busy_q       out  NUM_CH        channel in RUN or PAUSED
//   irq_q        out  NUM_CH        sticky end-event flag
module multi_channel_timer #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         start_i,
  input  logic [NUM_CH-1:0]         stop_i,
  input  logic [NUM_CH-1:0]         pause_i,
  input  logic [NUM_CH-1:0]         periodic_i,
  input  logic [NUM_CH*WIDTH-1:0]   n_i,
  input  logic [NUM_CH-1:0]         irq_clr_i,
  output logic [NUM_CH*WIDTH-1:0]   curr_time_q,
  output logic [NUM_CH-1:0]         curr_end_q,
  output logic [NUM_CH-1:0]         busy_q,
  output logic [NUM_CH-1:0]         irq_q
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, n_q, n_d, count_inc, n_in;
    logic             mode_q, mode_d, end_q, end_d, irq_r, irq_d, end_evt;

    assign n_in = n_i[k*WIDTH +: WIDTH];

    // In RUN, count==n_q only happens in periodic mode (one-shot leaves for
    // DONE on the same edge), so reaching n_q reloads to 1.
    assign count_inc = (count_q == n_q) ? WIDTH'(1) : count_q + 1'b1;

    always_comb begin
      state_d = state_q;
      count_d = count_q;
      n_d     = n_q;
      mode_d  = mode_q;
      end_d   = end_q;
      end_evt = 1'b0;
      if (stop_i[k]) begin
        state_d = IDLE;
        count_d = '0;
        end_d   = 1'b0;
      end else if (start_i[k]) begin
        n_d     = n_in;
        count_d = '0;
        if (n_in == '0) begin
          // Zero-length delay ends immediately and never reloads.
          state_d = DONE;
          mode_d  = 1'b0;
          end_d   = 1'b1;
          end_evt = 1'b1;
        end else begin
          state_d = RUN;
          mode_d  = periodic_i[k];
          end_d   = 1'b0;
        end
      end else if (state_q == RUN || state_q == PAUSED) begin
        if (pause_i[k]) begin
          state_d = PAUSED;
          end_d   = 1'b0;
        end else begin
          // Releasing pause increments on the same edge, so a pause of P
          // edges delays the end event by exactly P cycles.
          count_d = count_inc;
          end_d   = (count_inc == n_q);
          end_evt = end_d;
          state_d = (end_d && !mode_q) ? DONE : RUN;
        end
      end
      irq_d = end_evt | (irq_r & ~irq_clr_i[k]);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= IDLE;
        count_q <= '0;
        n_q     <= '0;
        mode_q  <= 1'b0;
        end_q   <= 1'b0;
        irq_r   <= 1'b0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
        n_q     <= n_d;
        mode_q  <= mode_d;
        end_q   <= end_d;
        irq_r   <= irq_d;
      end
    end

    assign curr_time_q[k*WIDTH +: WIDTH] = count_q;
    assign curr_end_q[k] = end_q;
    assign busy_q[k]     = (state_q == RUN) || (state_q == PAUSED);
    assign irq_q[k]      = irq_r;
  end

endmodule
